// File: rtl/complex_delay_pkg.sv
// Shared types and constants for the complex delay line.
package complex_delay_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int MAX_DELAY_LEN = 4096;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } sample_t;

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port, single-clock, read-first storage for the delay line; no reset.
module delay_ram
    import complex_delay_pkg::*;
#(
    parameter int WIDTH  = 2 * DATA_W_DEF,
    parameter int DEPTH  = 29,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Combinational read sees the pre-edge contents, so a same-address write is read-first.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/complex_delay.sv
// Fixed-length delay line for complex samples: y[m] = x[m - delay_len] over enabled cycles.
module complex_delay
    import complex_delay_pkg::*;
#(
    parameter int delay_len = 30,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] x_in_re,
    input  logic signed [DATA_W-1:0] x_in_im,
    output logic signed [DATA_W-1:0] x_out_re,
    output logic signed [DATA_W-1:0] x_out_im
);

    generate
        if (delay_len == 1) begin : g_len1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    x_out_re <= '0;
                    x_out_im <= '0;
                end else if (enable) begin
                    x_out_re <= x_in_re;
                    x_out_im <= x_in_im;
                end
            end
        end else if (delay_len == 2) begin : g_len2
            logic signed [DATA_W-1:0] stage_re;
            logic signed [DATA_W-1:0] stage_im;
            logic                     filled;

            always_ff @(posedge clk) begin
                if (enable) begin
                    stage_re <= x_in_re;
                    stage_im <= x_in_im;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    filled   <= 1'b0;
                    x_out_re <= '0;
                    x_out_im <= '0;
                end else if (enable) begin
                    filled   <= 1'b1;
                    x_out_re <= filled ? stage_re : '0;
                    x_out_im <= filled ? stage_im : '0;
                end
            end
        end else begin : g_ram
            localparam int D      = delay_len - 1;
            localparam int PTR_W  = $clog2(D);
            localparam int FILL_W = $clog2(delay_len);
            localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(D - 1);
            localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(D);

            logic [PTR_W-1:0]    ptr;
            logic [FILL_W-1:0]   fill;
            logic [2*DATA_W-1:0] rd_data;

            delay_ram #(
                .WIDTH  (2 * DATA_W),
                .DEPTH  (D),
                .ADDR_W (PTR_W)
            ) u_ram (
                .clk     (clk),
                .we      (enable),
                .wr_addr (ptr),
                .rd_addr (ptr),
                .wr_data ({x_in_re, x_in_im}),
                .rd_data (rd_data)
            );

            // Fill count saturates at the buffer depth; until then stale RAM is masked to zero.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ptr      <= '0;
                    fill     <= '0;
                    x_out_re <= '0;
                    x_out_im <= '0;
                end else if (enable) begin
                    ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
                    if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
                    if (fill == FILL_FULL) begin
                        x_out_re <= rd_data[2*DATA_W-1:DATA_W];
                        x_out_im <= rd_data[DATA_W-1:0];
                    end else begin
                        x_out_re <= '0;
                        x_out_im <= '0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_complex_delay.sv
// Bench for complex_delay at delay_len 1, 2 and 30 against a history-array reference model.
module tb_complex_delay;
    import complex_delay_pkg::*;

    logic clk;
    logic rst_n;
    logic enable;
    logic signed [15:0] in_re, in_im;
    logic signed [15:0] o1_re, o1_im, o2_re, o2_im, o30_re, o30_im;

    int checks   = 0;
    int failures = 0;

    complex_delay #(.delay_len(1), .DATA_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .x_in_re(in_re), .x_in_im(in_im), .x_out_re(o1_re), .x_out_im(o1_im)
    );
    complex_delay #(.delay_len(2), .DATA_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .x_in_re(in_re), .x_in_im(in_im), .x_out_re(o2_re), .x_out_im(o2_im)
    );
    complex_delay #(.delay_len(30), .DATA_W(16)) u_d30 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .x_in_re(in_re), .x_in_im(in_im), .x_out_re(o30_re), .x_out_im(o30_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every enabled input since reset, indexed by enabled-cycle count.
    sample_t hist [MAX_DELAY_LEN];
    int      n = 0;
    int      lens [3] = '{1, 2, 30};
    int      exp_re [3] = '{0, 0, 0};
    int      exp_im [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic en, input logic rstv, input int re, input int im);
        enable = en;
        rst_n  = rstv;
        in_re  = re[15:0];
        in_im  = im[15:0];
        @(posedge clk);
        #1;
        if (!rstv) begin
            n = 0;
            for (int i = 0; i < 3; i++) begin
                exp_re[i] = 0;
                exp_im[i] = 0;
            end
        end else if (en) begin
            hist[n].re = in_re;
            hist[n].im = in_im;
            n++;
            for (int i = 0; i < 3; i++) begin
                if (n >= lens[i]) begin
                    exp_re[i] = int'(hist[n - lens[i]].re);
                    exp_im[i] = int'(hist[n - lens[i]].im);
                end else begin
                    exp_re[i] = 0;
                    exp_im[i] = 0;
                end
            end
        end
        chk("d1_re",  o1_re,  exp_re[0]);
        chk("d1_im",  o1_im,  exp_im[0]);
        chk("d2_re",  o2_re,  exp_re[1]);
        chk("d2_im",  o2_im,  exp_im[1]);
        chk("d30_re", o30_re, exp_re[2]);
        chk("d30_im", o30_im, exp_im[2]);
    endtask

    initial begin
        int r_re, r_im;
        logic en, rv;

        step(1'b1, 1'b0, 7, 7);
        step(1'b0, 1'b0, 0, 0);
        chk("reset_pin_d30", o30_re, 0);

        // Impulse
        step(1'b1, 1'b1, 2, 1);
        chk("imp_d1_pin", o1_re, 2);
        for (int i = 2; i <= 40; i++) begin
            step(1'b1, 1'b1, 0, 0);
            if (i == 2)  chk("imp_d2_pin_re", o2_re, 2);
            if (i == 29) chk("imp_d30_early_pin", o30_re, 0);
            if (i == 30) begin
                chk("imp_d30_pin_re", o30_re, 2);
                chk("imp_d30_pin_im", o30_im, 1);
            end
            if (i == 31) chk("imp_d30_after_pin", o30_re, 0);
        end

        // Ramp across pointer wrap
        step(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b1, k, -k);
            if (k == 40) begin
                chk("ramp_pin_re", o30_re, 11);
                chk("ramp_pin_im", o30_im, -11);
            end
        end

        // Enable low every third cycle
        step(1'b1, 1'b0, 0, 0);
        for (int c = 0; c < 150; c++) begin
            step(logic'(c % 3 != 2), 1'b1, c, -c);
        end

        // Reset mid-stream
        step(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 100; k++) begin
            step(1'b1, logic'(k != 50), k, -k);
            if (k == 50) chk("midrst_zero_pin", o30_re, 0);
            if (k == 80) chk("midrst_restart_pin", o30_re, 51);
        end

        // Random traffic with occasional extremes, gaps and resets
        step(1'b1, 1'b0, 0, 0);
        for (int s = 0; s < 400; s++) begin
            en   = ($urandom_range(0, 3) != 0);
            rv   = ($urandom_range(0, 63) != 0);
            r_re = int'($urandom_range(0, 65535)) - 32768;
            r_im = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) r_re = -32768;
            if ($urandom_range(0, 7) == 0) r_im = 32767;
            step(en, rv, r_re, r_im);
        end

        // Extremes pass through unchanged
        step(1'b1, 1'b1, -32768, 32767);
        chk("ext_d1_re_pin", o1_re, -32768);
        chk("ext_d1_im_pin", o1_im, 32767);
        step(1'b1, 1'b1, 32767, -32768);
        chk("ext_d2_re_pin", o2_re, -32768);
        chk("ext_d2_im_pin", o2_im, 32767);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
